// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encodings and grant constants for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } state_t;
    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_HOST = 1'b1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU data port, host/loader port and RAM port bundled for the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              cpu_rena;
    logic              cpu_wena;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              host_req;
    logic              host_we;
    logic              host_lock;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport master (
        output cpu_rena, cpu_wena, cpu_addr, cpu_wdata, host_req, host_we, host_lock,
               host_addr, host_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, host_gnt, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  cpu_rena, cpu_wena, cpu_addr, cpu_wdata, host_req, host_we, host_lock,
               host_addr, host_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, host_gnt, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; host lock overrides fairness
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req_cpu_i,
    input  logic req_host_i,
    input  logic lock_i,
    input  logic last_i,
    output logic valid_o,
    output logic gnt_o
);
    // locked host wins outright; a tie goes to whoever was not served last
    always_comb begin
        valid_o = req_cpu_i | req_host_i;
        gnt_o   = (lock_i && req_host_i)     ? GNT_HOST :
                  (req_cpu_i && req_host_i)  ? ~last_i  :
                  req_host_i                 ? GNT_HOST : GNT_CPU;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU data port and the host port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   cpu_req, arb_valid, arb_gnt, idle, cpu_g, host_g;

    assign cpu_req = bus.cpu_rena | bus.cpu_wena;
    assign idle    = state_q == IDLE;
    assign cpu_g   = reset && idle && arb_valid && arb_gnt == GNT_CPU;
    assign host_g  = reset && idle && arb_valid && arb_gnt == GNT_HOST;

    rr_arb2 u_arb (
        .req_cpu_i  (cpu_req),
        .req_host_i (bus.host_req),
        .lock_i     (bus.host_lock),
        .last_i     (last_q),
        .valid_o    (arb_valid),
        .gnt_o      (arb_gnt)
    );

    // state and fairness history; reset leaves HOST as last so the CPU wins the first tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= GNT_HOST;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // reads park one cycle in a read state while the RAM returns data; writes stay in IDLE
    always_comb begin
        state_d = IDLE;
        last_d  = (cpu_g || host_g) ? arb_gnt : last_q;
        if (cpu_g && !bus.cpu_wena)
            state_d = CPU_RD;
        else if (host_g && !bus.host_we)
            state_d = HOST_RD;
    end

    // RAM muxing and requester responses, all held at zero while reset is asserted
    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.cpu_rdata   = '0;
        bus.cpu_stall   = 1'b0;
        bus.host_gnt    = 1'b0;
        bus.host_rvalid = 1'b0;
        bus.host_rdata  = '0;
        if (reset) begin
            bus.mem_en      = cpu_g | host_g;
            bus.mem_we      = cpu_g ? bus.cpu_wena : host_g & bus.host_we;
            bus.mem_addr    = cpu_g ? bus.cpu_addr[ADDR_W+1:2] : host_g ? bus.host_addr : '0;
            bus.mem_wdata   = cpu_g ? bus.cpu_wdata : host_g ? bus.host_wdata : '0;
            bus.cpu_rdata   = state_q == CPU_RD ? bus.mem_rdata : '0;
            bus.cpu_stall   = cpu_req && state_q != CPU_RD && !(cpu_g && bus.cpu_wena);
            bus.host_gnt    = host_g;
            bus.host_rvalid = state_q == HOST_RD;
            bus.host_rdata  = state_q == HOST_RD ? bus.mem_rdata : '0;
        end
    end
endmodule
